// File: rtl/vga_stream_timing.sv
// vga_stream_timing: VGA sync generator and pixel streamer fed from the read
// side of a show-ahead pixel FIFO whose words carry a start-of-frame flag.
// Detects FIFO underflow and frame misalignment, and resynchronises to the
// next SOF word without disturbing HS/VS timing.
// Optional build macro VGA_TESTPATTERN_EN adds input pattern_sel, which
// replaces the FIFO path with a 16-pixel grid while in RUN.
module vga_stream_timing #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_RGB = DATA_WIDTH'(24'h0000FF)
) (
  input  logic                  pixel_clk,
  input  logic                  pixel_rst,
  input  logic                  enable,
  input  logic                  clr_status,
`ifdef VGA_TESTPATTERN_EN
  input  logic                  pattern_sel,
`endif
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_sof,
  input  logic                  fifo_rempty,
  output logic                  fifo_read,
  output logic                  HS,
  output logic                  VS,
  output logic                  BLANK,
  output logic [DATA_WIDTH-1:0] RGB,
  output logic                  frame_start,
  output logic                  underflow,
  output logic                  sync_err,
  output logic                  busy
);

  localparam int HBLANK = HFP + HPULSE + HBP;
  localparam int HTOTAL = HBLANK + HDISP;
  localparam int VBLANK = VFP + VPULSE + VBP;
  localparam int VTOTAL = VBLANK + VDISP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(HBLANK);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(VBLANK);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(VFP + VPULSE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESYNC
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [HW-1:0]           h_cnt;
  logic [HW-1:0]           h_next;
  logic [VW-1:0]           v_cnt;
  logic [VW-1:0]           v_next;
  logic                    active;
  logic                    first_px;
  logic                    line_wrap;
  logic                    frame_wrap;
  logic                    in_hsync;
  logic                    in_vsync;
  logic                    sof_ok;
  logic                    set_uf;
  logic                    set_se;
  logic [DATA_WIDTH-1:0]   rgb_next;
  logic                    pattern_on;
  logic [DATA_WIDTH-1:0]   pattern_rgb;

  // Position decode: display regions, sync windows and the expected SOF slot.
  always_comb begin
    active     = (h_cnt >= H_ACT) && (v_cnt >= V_ACT);
    first_px   = (h_cnt == H_ACT) && (v_cnt == V_ACT);
    line_wrap  = (h_cnt == H_LAST);
    frame_wrap = line_wrap && (v_cnt == V_LAST);
    in_hsync   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    in_vsync   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    sof_ok     = (fifo_sof == first_px);
  end

`ifdef VGA_TESTPATTERN_EN
  // Grid pattern: a bright line every 16 pixels/lines from the active origin.
  always_comb begin
    pattern_on  = pattern_sel;
    pattern_rgb = '0;
    if ((((int'(h_cnt) - HBLANK) % 16) == 0) ||
        (((int'(v_cnt) - VBLANK) % 16) == 0)) begin
      pattern_rgb = '1;
    end
  end
`else
  assign pattern_on  = 1'b0;
  assign pattern_rgb = '0;
`endif

  // Counters run freely outside IDLE; IDLE parks them at the frame origin.
  always_comb begin
    h_next = '0;
    v_next = '0;
    if (state != ST_IDLE) begin
      if (line_wrap) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_next = h_cnt + HW'(1);
        v_next = v_cnt;
      end
    end
  end

  // Next state, FIFO pop and next pixel; a stop or resync resolves at frame wrap.
  always_comb begin
    state_next = state;
    fifo_read  = 1'b0;
    rgb_next   = '0;
    set_uf     = 1'b0;
    set_se     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (pattern_on) begin
          if (active) rgb_next = pattern_rgb;
        end else if (active) begin
          if (fifo_rempty) begin
            rgb_next = UNDERFLOW_RGB;
            set_uf   = 1'b1;
          end else if (sof_ok) begin
            fifo_read = 1'b1;
            rgb_next  = fifo_rdata;
          end else begin
            rgb_next   = UNDERFLOW_RGB;
            set_se     = 1'b1;
            state_next = ST_RESYNC;
          end
        end
        if (frame_wrap) state_next = enable ? ST_RUN : ST_IDLE;
      end
      ST_RESYNC: begin
        fifo_read = !fifo_rempty && !fifo_sof;
        if (active) rgb_next = UNDERFLOW_RGB;
        if (frame_wrap) state_next = enable ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (pixel_rst) fifo_read = 1'b0;
  end

  // State, counters and registered video outputs (one cycle behind counters).
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state       <= ST_IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      BLANK       <= 1'b0;
      RGB         <= '0;
      frame_start <= 1'b0;
    end else begin
      state <= state_next;
      h_cnt <= h_next;
      v_cnt <= v_next;
      if (state == ST_IDLE) begin
        HS          <= ~HS_POL;
        VS          <= ~VS_POL;
        BLANK       <= 1'b0;
        RGB         <= '0;
        frame_start <= 1'b0;
      end else begin
        HS          <= in_hsync ? HS_POL : ~HS_POL;
        VS          <= in_vsync ? VS_POL : ~VS_POL;
        BLANK       <= active;
        RGB         <= rgb_next;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

  // Sticky status flags; a new event wins over a simultaneous clear.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (set_uf)          underflow <= 1'b1;
      else if (clr_status) underflow <= 1'b0;
      if (set_se)          sync_err  <= 1'b1;
      else if (clr_status) sync_err  <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_vga_stream_timing.sv
// tb_vga_stream_timing: self-checking bench for vga_stream_timing using a
// small-frame configuration (14 x 7 = 98 cycles/frame). A behavioural model
// tracks the frame position as a single cycle index and derives every output
// from it; directed scenarios pin that model with literal expectations.
module tb_vga_stream_timing;

  localparam int HDISP = 8, HFP = 2, HPULSE = 2, HBP = 2;
  localparam int VDISP = 4, VFP = 1, VPULSE = 1, VBP = 1;
  localparam int HBLANK = HFP + HPULSE + HBP;
  localparam int VBLANK = VFP + VPULSE + VBP;
  localparam int HTOTAL = HBLANK + HDISP;
  localparam int VTOTAL = VBLANK + VDISP;
  localparam int FRAME  = HTOTAL * VTOTAL;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;
  localparam logic [23:0] FILL = 24'h0000FF;
  localparam int M_IDLE = 0, M_RUN = 1, M_RESYNC = 2;
  localparam int HIST = 8192;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        enable = 1'b0;
  logic        clr_status = 1'b0;
  logic [23:0] fifo_rdata = '0;
  logic        fifo_sof = 1'b0;
  logic        fifo_rempty = 1'b1;
  logic        fifo_read;
  logic        HS, VS, BLANK, frame_start, underflow, sync_err, busy;
  logic [23:0] RGB;

  always #5 pixel_clk = ~pixel_clk;

  vga_stream_timing #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .DATA_WIDTH(24), .UNDERFLOW_RGB(FILL)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .enable(enable),
    .clr_status(clr_status), .fifo_rdata(fifo_rdata), .fifo_sof(fifo_sof),
    .fifo_rempty(fifo_rempty), .fifo_read(fifo_read), .HS(HS), .VS(VS),
    .BLANK(BLANK), .RGB(RGB), .frame_start(frame_start),
    .underflow(underflow), .sync_err(sync_err), .busy(busy)
  );

  typedef struct packed {
    logic        sof;
    logic [23:0] data;
  } word_t;

  word_t fifo_q[$];

  // stimulus requests
  bit rst_req = 1'b1, en_req = 1'b0, clr_req = 1'b0;
  int stall_pct = 0;

  // model state and expected registered outputs
  int m_mode = M_IDLE, m_pos = 0, m_frames = 0;
  logic e_hs = !HS_POL, e_vs = !VS_POL, e_blank = 1'b0, e_fs = 1'b0;
  logic e_uf = 1'b0, e_se = 1'b0, e_busy = 1'b0;
  logic [23:0] e_rgb = '0;

  // bookkeeping
  int n_cmp = 0, n_bad = 0, cyc = 0, pops = 0, pops_resync = 0;
  bit hs_h[HIST], bl_h[HIST], fs_h[HIST], uf_h[HIST];
  logic [23:0] rgb_h[HIST];
  int fs_list[$];
  logic [23:0] px_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    chk("HS", HS, e_hs);
    chk("VS", VS, e_vs);
    chk("BLANK", BLANK, e_blank);
    chk("RGB", RGB, e_rgb);
    chk("frame_start", frame_start, e_fs);
    chk("underflow", underflow, e_uf);
    chk("sync_err", sync_err, e_se);
    chk("busy", busy, e_busy);
  endtask

  task automatic applyStimulus();
    pixel_rst  = rst_req;
    enable     = en_req;
    clr_status = clr_req;
    if (fifo_q.size() == 0 || $urandom_range(99) < stall_pct) begin
      fifo_rempty = 1'b1;
      fifo_rdata  = 24'($urandom);
      fifo_sof    = 1'($urandom);
    end else begin
      fifo_rempty = 1'b0;
      fifo_rdata  = fifo_q[0].data;
      fifo_sof    = fifo_q[0].sof;
    end
  endtask

  task automatic model_read(output bit rd);
    int h, v;
    bit act, first;
    h = m_pos % HTOTAL;
    v = m_pos / HTOTAL;
    act = (h >= HBLANK) && (v >= VBLANK);
    first = (h == HBLANK) && (v == VBLANK);
    rd = 1'b0;
    if (!pixel_rst) begin
      if (m_mode == M_RUN) rd = act && !fifo_rempty && (fifo_sof == first);
      else if (m_mode == M_RESYNC) rd = !fifo_rempty && !fifo_sof;
    end
  endtask

  task automatic model_edge();
    int h, v, nxt;
    bit act, first, set_uf, set_se;
    h = m_pos % HTOTAL;
    v = m_pos / HTOTAL;
    act = (h >= HBLANK) && (v >= VBLANK);
    first = (h == HBLANK) && (v == VBLANK);
    set_uf = 1'b0;
    set_se = 1'b0;
    if (pixel_rst) begin
      m_mode = M_IDLE; m_pos = 0;
      e_hs = !HS_POL; e_vs = !VS_POL; e_blank = 1'b0; e_rgb = '0; e_fs = 1'b0;
      e_uf = 1'b0; e_se = 1'b0;
    end else if (m_mode == M_IDLE) begin
      e_hs = !HS_POL; e_vs = !VS_POL; e_blank = 1'b0; e_rgb = '0; e_fs = 1'b0;
      if (clr_status) begin e_uf = 1'b0; e_se = 1'b0; end
      if (enable) m_mode = M_RUN;
      m_pos = 0;
    end else begin
      e_hs = (h >= HFP && h < HFP + HPULSE) ? HS_POL : !HS_POL;
      e_vs = (v >= VFP && v < VFP + VPULSE) ? VS_POL : !VS_POL;
      e_blank = act;
      e_fs = (m_pos == 0);
      e_rgb = '0;
      nxt = m_mode;
      if (act) begin
        if (m_mode == M_RESYNC) e_rgb = FILL;
        else if (fifo_rempty) begin e_rgb = FILL; set_uf = 1'b1; end
        else if (fifo_sof == first) e_rgb = fifo_rdata;
        else begin e_rgb = FILL; set_se = 1'b1; nxt = M_RESYNC; end
      end
      if (set_uf) e_uf = 1'b1; else if (clr_status) e_uf = 1'b0;
      if (set_se) e_se = 1'b1; else if (clr_status) e_se = 1'b0;
      if (m_pos == FRAME - 1) begin
        nxt = enable ? M_RUN : M_IDLE;
        m_frames++;
        m_pos = 0;
      end else begin
        m_pos++;
      end
      m_mode = nxt;
    end
    e_busy = (m_mode != M_IDLE);
  endtask

  // one clock cycle: check registered outputs, drive inputs, check the pop, advance model
  task automatic step();
    bit rd;
    word_t w;
    @(negedge pixel_clk);
    checkOutput();
    if (cyc < HIST) begin
      hs_h[cyc] = HS; bl_h[cyc] = BLANK; fs_h[cyc] = frame_start;
      uf_h[cyc] = underflow; rgb_h[cyc] = RGB;
    end
    applyStimulus();
    #1;
    model_read(rd);
    chk("fifo_read", fifo_read, rd);
    if (fifo_read && !fifo_rempty && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      pops++;
      if (m_mode == M_RESYNC) pops_resync++;
    end
    model_edge();
    cyc++;
  endtask

  task automatic reset_dut();
    rst_req = 1'b1; en_req = 1'b0; clr_req = 1'b0; stall_pct = 0;
    step();
    step();
    rst_req = 1'b0;
  endtask

  task automatic push_words(input int first_val, input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.sof = (i == 0);
      w.data = 24'(first_val + i);
      fifo_q.push_back(w);
    end
  endtask

  task automatic push_random_frame();
    word_t w;
    int junk, n, stray;
    junk  = ($urandom_range(9) == 0) ? int'($urandom_range(3, 1)) : 0;
    n     = ($urandom_range(9) == 0) ? 32 - int'($urandom_range(5, 1)) : 32;
    stray = ($urandom_range(9) == 0) ? int'($urandom_range(31, 1)) : -1;
    for (int j = 0; j < junk; j++) begin
      w.sof = 1'b0; w.data = 24'($urandom);
      fifo_q.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      w.sof = (i == 0) || (i == stray);
      w.data = 24'($urandom);
      fifo_q.push_back(w);
    end
  endtask

  task automatic collect_fs(input int c_from, input int c_to);
    fs_list.delete();
    for (int c = c_from; c < c_to && c < HIST; c++)
      if (fs_h[c]) fs_list.push_back(c);
  endtask

  task automatic collect_px(input int c0);
    px_q.delete();
    for (int c = c0; c < c0 + FRAME && c < HIST; c++)
      if (bl_h[c]) px_q.push_back(rgb_h[c]);
  endtask

  // count pixels of the frame starting at c0 that differ from first_val, first_val+1, ...
  task automatic seq_errors(input int c0, input int first_val, output int errs);
    collect_px(c0);
    errs = (px_q.size() == 32) ? 0 : 1000;
    foreach (px_q[i]) if (px_q[i] !== 24'(first_val + i)) errs++;
  endtask

  initial begin
    int c_start, c_prio, errs, n_fill, last_fall;
    bit done;

    repeat (3) @(posedge pixel_clk);

    // ---- idle: FIFO holds data but nothing may be popped ----
    $display("[TB] idle");
    push_words(1, 32);
    push_words(33, 32);
    reset_dut();
    for (int k = 0; k < 200; k++) begin
      clr_req = ($urandom_range(9) == 0);
      step();
    end
    clr_req = 1'b0;
    step();
    chk("idle_HS", HS, 1);
    chk("idle_VS", VS, 1);
    chk("idle_BLANK", BLANK, 0);
    chk("idle_RGB", RGB, 0);
    chk("idle_busy", busy, 0);
    chk("idle_pops", pops, 0);

    // ---- nominal two frames, then stop requested at h=5,v=4 of frame 2 ----
    $display("[TB] nominal and stop");
    pops = 0; m_frames = 0; c_start = cyc; en_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (m_mode != M_IDLE && m_frames == 1 && m_pos == 4 * HTOTAL + 5) en_req = 1'b0;
      step();
      if (!en_req && m_mode == M_IDLE && m_frames >= 2) done = 1'b1;
    end
    for (int k = 0; k < 30; k++) step();
    collect_fs(c_start, cyc);
    chk("nom_fs_count", fs_list.size(), 2);
    if (fs_list.size() == 2) begin
      chk("nom_fs_period", fs_list[1] - fs_list[0], FRAME);
      chk("nom_hs_h1", hs_h[fs_list[0] + 1], 1);
      chk("nom_hs_h2", hs_h[fs_list[0] + 2], 0);
      chk("nom_hs_h3", hs_h[fs_list[0] + 3], 0);
      chk("nom_hs_h4", hs_h[fs_list[0] + 4], 1);
      chk("nom_blank_v3h5", bl_h[fs_list[0] + 3 * HTOTAL + 5], 0);
      chk("nom_blank_v3h6", bl_h[fs_list[0] + 3 * HTOTAL + 6], 1);
      seq_errors(fs_list[0], 1, errs);
      chk("nom_frame1_rgb", errs, 0);
      seq_errors(fs_list[1], 33, errs);
      chk("nom_frame2_rgb", errs, 0);
    end
    chk("nom_pops", pops, 64);
    chk("nom_underflow", underflow, 0);
    chk("nom_sync_err", sync_err, 0);
    chk("stop_busy", busy, 0);
    chk("stop_blank", BLANK, 0);

    // ---- underflow: only 20 words; clear collides with the last fill pixel ----
    $display("[TB] underflow");
    fifo_q.delete();
    reset_dut();
    push_words(1, 20);
    m_frames = 0; c_start = cyc; c_prio = -10; en_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (m_mode != M_IDLE && m_pos == 90) en_req = 1'b0;
      clr_req = 1'b0;
      if (m_mode == M_RUN && m_pos == FRAME - 1) begin
        clr_req = 1'b1;
        c_prio = cyc;
      end
      if (cyc == c_prio + 1) clr_req = 1'b1;
      step();
      if (c_prio >= 0 && cyc > c_prio + 4) done = 1'b1;
    end
    clr_req = 1'b0;
    collect_fs(c_start, cyc);
    chk("uf_fs_count", fs_list.size(), 1);
    if (fs_list.size() >= 1) begin
      collect_px(fs_list[0]);
      n_fill = 0;
      errs = 0;
      foreach (px_q[i]) begin
        if (px_q[i] === FILL) n_fill++;
        if (i < 20 && px_q[i] !== 24'(i + 1)) errs++;
      end
      chk("uf_fill_count", n_fill, 12);
      chk("uf_head_rgb", errs, 0);
      last_fall = -1;
      for (int c = fs_list[0] + 1; c < fs_list[0] + FRAME; c++) begin
        if (hs_h[c - 1] && !hs_h[c]) begin
          if (last_fall >= 0) chk("uf_hs_period", c - last_fall, HTOTAL);
          last_fall = c;
        end
      end
    end
    if (c_prio >= 0) begin
      chk("prio_set_wins", uf_h[c_prio + 1], 1);
      chk("prio_clr_alone", uf_h[c_prio + 2], 0);
    end else begin
      chk("prio_reached", 0, 1);
    end

    // ---- misalignment: 3 junk words ahead of two SOF frames ----
    $display("[TB] misalign");
    fifo_q.delete();
    reset_dut();
    begin
      word_t w;
      for (int j = 0; j < 3; j++) begin
        w.sof = 1'b0; w.data = 24'hA00001 + 24'(j);
        fifo_q.push_back(w);
      end
    end
    push_words(100, 32);
    push_words(200, 32);
    pops_resync = 0; m_frames = 0; c_start = cyc; en_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      if (m_frames >= 2) en_req = 1'b0;
      step();
      if (!en_req && m_mode == M_IDLE) done = 1'b1;
    end
    step();
    collect_fs(c_start, cyc);
    chk("mis_fs_count", fs_list.size(), 3);
    chk("mis_junk_pops", pops_resync, 3);
    chk("mis_sync_err", sync_err, 1);
    chk("mis_underflow", underflow, 0);
    if (fs_list.size() == 3) begin
      collect_px(fs_list[0]);
      n_fill = 0;
      foreach (px_q[i]) if (px_q[i] === FILL) n_fill++;
      chk("mis_frame1_fill", n_fill, 32);
      seq_errors(fs_list[1], 100, errs);
      chk("mis_frame2_rgb", errs, 0);
      seq_errors(fs_list[2], 200, errs);
      chk("mis_frame3_rgb", errs, 0);
    end

    // ---- randomized traffic: stalls, junk, stray SOF, enable toggles, clears, resets ----
    $display("[TB] random");
    fifo_q.delete();
    reset_dut();
    stall_pct = 4;
    en_req = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      while (fifo_q.size() < 40) push_random_frame();
      if ($urandom_range(149) == 0) en_req = !en_req;
      clr_req = ($urandom_range(19) == 0);
      rst_req = ($urandom_range(599) == 0);
      step();
    end
    rst_req = 1'b0;
    clr_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
